// File: rtl/hd44780_pkg.sv
// Shared types and byte constants for the HD44780 frame sequencer.
// Also holds the BCD-digit-to-ASCII helper and the init command table.
package hd44780_pkg;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT_EMIT,
    S_INIT_WAIT,
    S_IDLE,
    S_EMIT,
    S_WAIT
  } state_e;

  localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_M     = 8'h4D;

  // Frame index width covers the largest frame: 1 + 3*8 - 1 + 3 = 27 bytes.
  localparam int IDX_W = 5;

  function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
    return (n > 4'd9) ? ASCII_QMARK : (ASCII_0 | {4'h0, n});
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_8BIT_2L;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY_INC;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/hd44780_frame_rom.sv
// Maps a frame byte index to {rs, byte}: DDRAM command, BCD digits with
// separators, then the optional " AM"/" PM" suffix.
module hd44780_frame_rom
  import hd44780_pkg::*;
#(
  parameter int         N_FIELDS  = 3,
  parameter logic [7:0] SEP_CHAR  = 8'h3A,
  parameter bit         SHOW_AMPM = 1'b1,
  parameter logic [6:0] LINE_ADDR = 7'h00
) (
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [8*N_FIELDS-1:0] fields_i,
  input  logic                  pm_i,
  output logic                  rs_o,
  output logic [7:0]            byte_o
);

  int j;

  always_comb begin
    rs_o   = 1'b1;
    byte_o = ASCII_SPACE;
    j      = int'(idx_i) - 1;
    if (idx_i == '0) begin
      rs_o   = 1'b0;
      byte_o = CMD_SET_DDRAM | {1'b0, LINE_ADDR};
    end else begin
      // Field k occupies character slots 3k (hi), 3k+1 (lo), 3k+2 (separator).
      for (int k = 0; k < N_FIELDS; k++) begin
        if (j == 3*k)
          byte_o = bcd_ascii(fields_i[8*(N_FIELDS-1-k)+4 +: 4]);
        else if (j == 3*k + 1)
          byte_o = bcd_ascii(fields_i[8*(N_FIELDS-1-k) +: 4]);
        else if (j == 3*k + 2 && k < N_FIELDS - 1)
          byte_o = SEP_CHAR;
      end
      if (SHOW_AMPM) begin
        if (j == 3*N_FIELDS - 1)
          byte_o = ASCII_SPACE;
        else if (j == 3*N_FIELDS)
          byte_o = pm_i ? ASCII_P : ASCII_A;
        else if (j == 3*N_FIELDS + 1)
          byte_o = ASCII_M;
      end
    end
  end

endmodule

// File: rtl/hd44780_frame_seq.sv
// HD44780 sequencer: power-on init, then one display frame per update request,
// streamed as {rs, byte} over valid/ready with tick-counted settle delays.
module hd44780_frame_seq
  import hd44780_pkg::*;
#(
  parameter int          N_FIELDS  = 3,
  parameter logic [7:0]  SEP_CHAR  = 8'h3A,
  parameter bit          SHOW_AMPM = 1'b1,
  parameter logic [6:0]  LINE_ADDR = 7'h00,
  parameter logic [10:0] T_PWR     = 11'd1316,
  parameter logic [10:0] T_CMD     = 11'd32,
  parameter logic [10:0] T_CLR     = 11'd1224
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ena,
  input  logic                  i_update_pulse,
  input  logic                  i_pm,
  input  logic [8*N_FIELDS-1:0] i_fields,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic                  o_rs,
  output logic [7:0]            o_byte,
  output logic                  o_init_done,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int              FRAME_LEN = 3*N_FIELDS + (SHOW_AMPM ? 3 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [10:0]           cnt_q, cnt_d;
  logic [1:0]            init_idx_q, init_idx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [8*N_FIELDS-1:0] fld_q, fld_d;
  logic                  pm_q, pm_d;
  logic                  valid_q, valid_d;
  logic                  rs_q, rs_d;
  logic [7:0]            byte_q, byte_d;
  logic                  init_done_q, init_done_d;
  logic                  frame_done_q, frame_done_d;

  logic [10:0]      lim;
  logic             tick_done;
  logic             xfer;
  logic [IDX_W-1:0] rom_idx;
  logic             rom_rs;
  logic [7:0]       rom_byte;

  // ROM always looks one byte ahead: index 0 from IDLE, otherwise the successor.
  assign rom_idx = (state_q == S_IDLE) ? '0 : idx_q + IDX_W'(1);

  hd44780_frame_rom #(
    .N_FIELDS (N_FIELDS),
    .SEP_CHAR (SEP_CHAR),
    .SHOW_AMPM(SHOW_AMPM),
    .LINE_ADDR(LINE_ADDR)
  ) u_rom (
    .idx_i   (rom_idx),
    .fields_i(fld_q),
    .pm_i    (pm_q),
    .rs_o    (rom_rs),
    .byte_o  (rom_byte)
  );

  always_comb begin
    lim = T_CMD;
    if (state_q == S_PWR_WAIT)
      lim = T_PWR;
    else if (state_q == S_INIT_WAIT && init_idx_q == 2'd3)
      lim = T_CLR;
  end

  assign tick_done = i_ena && (cnt_q == lim - 11'd1);
  assign xfer      = valid_q && i_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    idx_d        = idx_q;
    fld_d        = fld_q;
    pm_d         = pm_q;
    valid_d      = valid_q;
    rs_d         = rs_q;
    byte_d       = byte_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_PWR_WAIT: begin
        if (i_ena) cnt_d = cnt_q + 11'd1;
        if (tick_done) begin
          cnt_d      = '0;
          init_idx_d = 2'd0;
          valid_d    = 1'b1;
          rs_d       = 1'b0;
          byte_d     = init_cmd(2'd0);
          state_d    = S_INIT_EMIT;
        end
      end
      S_INIT_EMIT: begin
        if (xfer) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: begin
        if (i_ena) cnt_d = cnt_q + 11'd1;
        if (tick_done) begin
          cnt_d = '0;
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            valid_d    = 1'b1;
            rs_d       = 1'b0;
            byte_d     = init_cmd(init_idx_q + 2'd1);
            state_d    = S_INIT_EMIT;
          end
        end
      end
      S_IDLE: begin
        if (i_update_pulse || pending_q) begin
          fld_d   = i_fields;
          pm_d    = i_pm;
          idx_d   = '0;
          valid_d = 1'b1;
          rs_d    = rom_rs;
          byte_d  = rom_byte;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (xfer) begin
          valid_d      = 1'b0;
          cnt_d        = '0;
          frame_done_d = (idx_q == LAST_IDX);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_ena) cnt_d = cnt_q + 11'd1;
        if (tick_done) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            valid_d = 1'b1;
            rs_d    = rom_rs;
            byte_d  = rom_byte;
            state_d = S_EMIT;
          end
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase
  end

  // A pending request is consumed in IDLE; a pulse landing that same cycle re-arms it.
  always_comb begin
    if (state_q == S_IDLE)
      pending_d = pending_q && i_update_pulse;
    else
      pending_d = pending_q || i_update_pulse;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_PWR_WAIT;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      fld_q        <= '0;
      pm_q         <= 1'b0;
      valid_q      <= 1'b0;
      rs_q         <= 1'b0;
      byte_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      fld_q        <= fld_d;
      pm_q         <= pm_d;
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      byte_q       <= byte_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_rs         = rs_q;
  assign o_byte       = byte_q;
  assign o_init_done  = init_done_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_hd44780_frame_seq.sv
// Directed bench for hd44780_frame_seq: scoreboard of expected {rs, byte},
// settle-gap checks and frame-done placement, default parameters.
module tb_hd44780_frame_seq;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ena;
  logic        i_update_pulse;
  logic        i_pm;
  logic [23:0] i_fields;
  logic        i_ready;
  logic        o_valid, o_rs, o_init_done, o_busy, o_frame_done;
  logic [7:0]  o_byte;

  hd44780_frame_seq dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ena         (i_ena),
    .i_update_pulse(i_update_pulse),
    .i_pm          (i_pm),
    .i_fields      (i_fields),
    .i_ready       (i_ready),
    .o_valid       (o_valid),
    .o_rs          (o_rs),
    .o_byte        (o_byte),
    .o_init_done   (o_init_done),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_fd  = 0;
  int          cyc   = 0;
  int          acc_cyc = 0;
  logic [7:0]  last_byte = 8'h00;
  logic [8:0]  sbq[$];
  int          gapq[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  task automatic push_frame(input logic [23:0] f, input bit pm);
    logic [7:0] b;
    sbq.push_back({1'b0, 8'h80});
    for (int k = 0; k < 3; k++) begin
      b = f[23-8*k -: 8];
      sbq.push_back({1'b1, enc(b[7:4])});
      sbq.push_back({1'b1, enc(b[3:0])});
      if (k < 2) sbq.push_back({1'b1, 8'h3A});
    end
    sbq.push_back({1'b1, 8'h20});
    sbq.push_back({1'b1, pm ? 8'h50 : 8'h41});
    sbq.push_back({1'b1, 8'h4D});
  endtask

  task automatic push_init();
    sbq.push_back({1'b0, 8'h38});
    sbq.push_back({1'b0, 8'h0C});
    sbq.push_back({1'b0, 8'h06});
    sbq.push_back({1'b0, 8'h01});
    gapq.push_back(1316);
    gapq.push_back(32);
    gapq.push_back(32);
    gapq.push_back(32);
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic pulse();
    i_update_pulse = 1'b1;
    step();
    i_update_pulse = 1'b0;
  endtask

  task automatic wait_acc(input int target, input string tag);
    int t = 0;
    while (n_acc < target && t < 2000) begin step(); t++; end
    check(tag, n_acc, target);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int t = 0;
    while ((n_fd < target || o_busy) && t < 3000) begin step(); t++; end
    check(tag, n_fd, target);
  endtask

  task automatic wait_init(input string tag);
    int t = 0;
    while (o_init_done !== 1'b1 && t < 3000) begin step(); t++; end
    check(tag, o_init_done, 1);
  endtask

  // Output monitor: pops the scoreboard on each transfer and times the idle gaps.
  initial begin
    int  lowrun = 0;
    int  g;
    bit  prev_valid = 0;
    bit  prev_done = 0;
    logic [8:0] e;
    forever begin
      @(negedge i_clk);
      if (i_reset_n !== 1'b1) begin
        lowrun = 0; prev_valid = 0; prev_done = 0;
      end else begin
        if (o_valid && !prev_valid && gapq.size() > 0) begin
          g = gapq.pop_front();
          check("settle_gap", lowrun, g);
        end
        if (o_init_done && !prev_done) check("clear_wait", lowrun, 1224);
        if (o_frame_done) begin
          n_fd++;
          check("fd_last_byte", last_byte, 8'h4D);
          check("fd_latency", cyc - acc_cyc, 1);
        end
        if (o_valid && i_ready) begin
          check("sb_nonempty", sbq.size() != 0, 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("byte", {o_rs, o_byte}, e);
          end
          n_acc++;
          acc_cyc   = cyc;
          last_byte = o_byte;
        end
        lowrun     = o_valid ? 0 : lowrun + 1;
        prev_valid = o_valid;
        prev_done  = o_init_done;
      end
    end
  end

  initial begin
    int  a0, f0;
    bit  stable;
    i_reset_n = 1'b0; i_ena = 1'b1; i_update_pulse = 1'b0;
    i_pm = 1'b0; i_fields = 24'h0; i_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_rs", o_rs, 0);
    check("rst_byte", o_byte, 8'h00);
    check("rst_init_done", o_init_done, 0);
    check("rst_busy", o_busy, 1);
    check("rst_frame_done", o_frame_done, 0);

    push_init();
    i_reset_n = 1'b1;
    wait_init("init1_timeout");
    check("init1_sb_empty", sbq.size(), 0);
    check("idle_busy", o_busy, 0);

    // Frame 12:34:56 PM with a 50-cycle stall on the third byte.
    i_fields = 24'h123456; i_pm = 1'b1;
    push_frame(24'h123456, 1'b1);
    a0 = n_acc; f0 = n_fd;
    pulse();
    wait_acc(a0 + 2, "stall_reach");
    i_ready = 1'b0;
    begin int t = 0; while (!o_valid && t < 100) begin step(); t++; end end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(o_valid === 1'b1 && o_rs === 1'b1 && o_byte === 8'h32)) stable = 1'b0;
      step();
    end
    check("stall_stable", stable, 1);
    i_ready = 1'b1;
    wait_frames(f0 + 1, "frame1_done");
    check("frame1_sb_empty", sbq.size(), 0);

    // Three pulses mid-frame, inputs changed mid-frame: old snapshot, then one new frame.
    i_fields = 24'h010203; i_pm = 1'b0;
    push_frame(24'h010203, 1'b0);
    a0 = n_acc; f0 = n_fd;
    pulse();
    wait_acc(a0 + 4, "mid_frame_reach");
    i_fields = 24'h987654; i_pm = 1'b1;
    push_frame(24'h987654, 1'b1);
    pulse(); repeat (20) step();
    pulse(); repeat (20) step();
    pulse();
    wait_frames(f0 + 2, "pending_frames");
    repeat (200) step();
    check("no_extra_frame", n_fd, f0 + 2);
    check("pending_sb_empty", sbq.size(), 0);
    check("pending_idle", o_busy, 0);

    // Out-of-range nibbles render as '?'.
    i_fields = 24'h1AB900; i_pm = 1'b0;
    push_frame(24'h1AB900, 1'b0);
    f0 = n_fd;
    pulse();
    wait_frames(f0 + 1, "qmark_frame");
    check("qmark_sb_empty", sbq.size(), 0);

    // Reset while the fifth byte is presented.
    i_fields = 24'h111111; i_pm = 1'b0;
    sbq.push_back({1'b0, 8'h80});
    sbq.push_back({1'b1, 8'h31});
    sbq.push_back({1'b1, 8'h31});
    sbq.push_back({1'b1, 8'h3A});
    a0 = n_acc;
    pulse();
    wait_acc(a0 + 4, "abort_reach");
    i_ready = 1'b0;
    begin int t = 0; while (!o_valid && t < 100) begin step(); t++; end end
    check("fifth_byte", {o_valid, o_byte}, {1'b1, 8'h31});
    i_reset_n = 1'b0;
    #1;
    check("abort_valid", o_valid, 0);
    check("abort_init_done", o_init_done, 0);
    check("abort_busy", o_busy, 1);
    check("abort_sb_empty", sbq.size(), 0);
    push_init();
    repeat (3) step();
    i_ready = 1'b1;
    i_reset_n = 1'b1;
    a0 = n_acc;
    wait_acc(a0 + 3, "reinit_reach");
    check("reinit_not_done", o_init_done, 0);
    wait_init("init2_timeout");
    repeat (100) step();
    check("reinit_sb_empty", sbq.size(), 0);
    check("reinit_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hd44780_frame_seq.md
Name: hd44780_frame_seq

Overview:
Parametrised successor to the clock's LCD control sequencer. Runs the HD44780 power-on init sequence, then on each update pulse emits one full display frame of N BCD fields with separators and an optional AM/PM suffix. Output is a byte stream (RS + 8-bit byte) to the downstream LCD bus writer over a valid/ready handshake. All settle delays are counted in i_ena ticks and set by parameters.

Parameters:
N_FIELDS, 3, number of 2-digit BCD fields shown (1..8)
SEP_CHAR, 8'h3A, ASCII separator between fields (':')
SHOW_AMPM, 1, append " AM"/" PM" after the last field
LINE_ADDR, 7'h00, DDRAM address of the frame's first character
T_PWR, 11'd1316, power-on wait before the first init command (ticks)
T_CMD, 11'd32, settle after each non-clear command or character (ticks)
T_CLR, 11'd1224, settle after clear display 0x01 (ticks)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_ena  in  1  timebase tick strobe; delay counters advance only on ticks
i_update_pulse  in  1  one-cycle request to redraw the frame
i_pm  in  1  PM flag, sampled at frame start
i_fields  in  8*N_FIELDS  packed BCD fields; field 0 = [8*N-1 -: 8], shown leftmost
i_ready  in  1  writer accepts the byte this cycle
o_valid  out  1  byte present on o_rs/o_byte
o_rs  out  1  0 = command, 1 = character data
o_byte  out  8  command or ASCII byte
o_init_done  out  1  high once the init sequence completes; stays high
o_busy  out  1  high outside IDLE
o_frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted

Behaviour:
- Reset (asynchronous, i_reset_n low): state PWR_WAIT, counters 0, pending 0. Outputs: o_valid 0, o_rs 0, o_byte 8'h00, o_init_done 0, o_busy 1, o_frame_done 0.
- States: PWR_WAIT, INIT_EMIT, INIT_WAIT, IDLE, EMIT, WAIT.
- PWR_WAIT: count T_PWR ticks, then go to INIT_EMIT.
- Init table, RS=0, in order: 0x38, 0x0C, 0x06, 0x01. Each byte goes out in INIT_EMIT, then INIT_WAIT counts T_CMD ticks (T_CLR for 0x01). After the last byte, o_init_done rises and the FSM goes to IDLE.
- Handshake:
  - o_valid is registered and holds o_rs/o_byte stable until the cycle where o_valid & i_ready.
  - Transfer takes effect on that edge: o_valid drops the next cycle and the delay counter clears.
  - The next byte is never presented before its settle count is complete.
  - i_ready is ignored while o_valid is low.
- Frame byte order:
  - Command 0x80|LINE_ADDR (RS=0).
  - Per field k: hi digit, lo digit, then SEP_CHAR if k < N_FIELDS-1.
  - If SHOW_AMPM: 0x20, 'A'(0x41) or 'P'(0x50), 'M'(0x4D).
  - Total bytes: 1 + 3*N_FIELDS - 1 + 3*SHOW_AMPM; 12 for the defaults.
- Digit encoding: nibble 0..9 becomes 0x30+nibble. Nibble >9 becomes '?' (0x3F).
- Snapshot: i_fields and i_pm are registered on the IDLE→EMIT transition. Input changes mid-frame do not affect the frame in progress.
- Update pulses:
  - A pulse in IDLE starts a frame on the next cycle.
  - A pulse during init or a frame sets pending. Multiple pulses collapse to one.
  - On returning to IDLE with pending set, the next frame starts immediately and pending clears.
  - A pulse in the same cycle pending clears keeps pending set.
- i_ena low: delay counters freeze. Handshake transfers still complete.
- Counter width is 11 bits, sized to the maximum of T_PWR and T_CLR. Terminal compare is count == T-1 on a tick.
- Reset mid-frame or mid-init: immediate abort to PWR_WAIT and a full re-init. No partial byte is held.

Decomposition:
- Shared package hd44780_pkg:
  - State enum.
  - Init command constants: CMD_FUNC_8BIT_2L 0x38, CMD_DISP_ON 0x0C, CMD_ENTRY_INC 0x06, CMD_CLEAR 0x01, CMD_SET_DDRAM 0x80.
  - ASCII constants: '0', '?', ' ', 'A', 'P', 'M'.
- Sub-module hd44780_frame_rom: combinational index→{rs, byte} mapper, covering the frame byte index, field snapshot and pm. It keeps the FSM free of per-field case arms.

Test Plan:
- Reset release, i_ena every cycle, i_ready tied 1 → bytes 0x38, 0x0C, 0x06, 0x01 with RS=0. First byte after 1316 ticks; gaps of 32, 32, 32 ticks; 1224-tick wait after 0x01, then o_init_done=1.
- Fields 0x12_34_56, i_pm=1, one update pulse → 0x80, 31 32 3A 33 34 3A 35 36 20 50 4D. o_frame_done pulses once after 0x4D.
- i_ready held 0 for 50 cycles on the third byte → o_valid and o_byte=0x32 stay stable. Sequence resumes unchanged, with no lost or duplicated bytes.
- Three update pulses during a frame, with i_fields changed mid-frame → current frame shows the old snapshot. Exactly one further frame follows, showing the new values.
- Field 0x1A → digit bytes 0x31, 0x3F.
- i_reset_n low during the 5th frame byte → o_valid is 0 immediately. After release, the full init sequence repeats and o_init_done=0 until it completes.
